// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the restoring divider: controller states and counter sizing.
package seq_restoring_divider_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The iteration counter must be able to hold WIDTH itself.
  function automatic int count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_sub_borrow_chain.sv
// Ripple subtractor a - b built from full-adder cells: subtrahend inverted, carry-in tied high.
module sub_borrow_chain #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] b_inv;
  logic         carry;

  assign b_inv = ~b;

  always_comb begin
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < W; i++) begin
      diff[i] = a[i] ^ b_inv[i] ^ carry;
      carry   = (a[i] & b_inv[i]) | (carry & (a[i] ^ b_inv[i]));
    end
  end

  assign borrow = ~carry;

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, with start/done handshake.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = count_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             sub_ok;

  assign trial = {p_q, q_q[WIDTH-1]};

  sub_borrow_chain #(
    .W(WIDTH + 1)
  ) u_sub (
    .a      (trial),
    .b      ({1'b0, dreg_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // A successful step always leaves the difference below the divisor, so its top bit is clear.
  assign sub_ok = ~(borrow | diff[WIDTH]);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    q_d     = q_q;
    dreg_d  = dreg_q;
    p_d     = p_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            q_d     = dividend;
            dreg_d  = divisor;
            p_d     = '0;
            count_d = CNT_INIT;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d     = sub_ok ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], sub_ok};
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          quot_d  = q_d;
          rem_d   = p_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      q_q     <= '0;
      dreg_q  <= '0;
      p_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      q_q     <= q_d;
      dreg_q  <= dreg_d;
      p_q     <= p_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed cases, abort, back-to-back and a full sweep.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  logic [2*W:0] sb[$];

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [W-1:0] qq, rr;
    if (d == 0) return {{W{1'b1}}, n, 1'b1};
    qq = n / d;
    rr = n % d;
    return {qq, rr, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done q=%0d r=%0d at %0t", quotient, remainder, $time);
      end else begin
        logic [2*W:0] e;
        e = sb.pop_front();
        chk("quotient", quotient, e[2*W:W+1]);
        chk("remainder", remainder, e[W:1]);
        chk("div_by_zero", div_by_zero, e[0]);
      end
    end
  end

  // Caller is at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d);
    int guard = 0;
    while (busy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL busy_timeout got=1 want=0 at %0t", $time);
    end
    start = 1'b1;
    dividend = n;
    divisor = d;
    sb.push_back(model(n, d));
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic timed_op(input logic [W-1:0] n, input logic [W-1:0] d, input int lat);
    int cnt = 0;
    int bcnt = 0;
    do_op(n, d);
    while (!done && cnt < 20) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, lat);
    chk("busy_cycles", bcnt, lat);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    timed_op(4'd13, 4'd4, 4);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("hold_quotient", quotient, 3);
    timed_op(4'd15, 4'd1, 4);
    timed_op(4'd3, 4'd7, 4);
    timed_op(4'd15, 4'd15, 4);
    @(posedge clk); #1;
    timed_op(4'd5, 4'd0, 0);
    @(posedge clk); #1;
    chk("dbz_done_one_cycle", done, 0);
    chk("dbz_no_busy", busy, 0);

    // Start while busy must be ignored.
    do_op(4'd9, 4'd2);
    @(posedge clk); #1;
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    // Back-to-back: second request lands in the done cycle of the first.
    timed_op(4'd12, 4'd5, 4);
    timed_op(4'd7, 4'd3, 4);
    @(posedge clk); #1;

    // Abort mid-operation.
    do_op(4'd14, 4'd3);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; chk("abort_no_done", done, 0); end
    timed_op(4'd14, 4'd3, 4);

    // Full sweep with random gaps between requests.
    for (int n = 0; n < (1 << W); n++) begin
      for (int d = 0; d < (1 << W); d++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_op(W'(n), W'(d));
      end
    end

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("drain_outstanding", sb.size(), 0);
    end
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
